// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small write FIFO, with a runtime baud divisor and 1/2 stop bits.
// Define UART_TX_PARITY_EN to add the parity_en/parity_odd ports and the PARITY state.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic                        stop2,
`ifdef UART_TX_PARITY_EN
    input  logic                        parity_en,
    input  logic                        parity_odd,
`endif
    input  logic                        wr_valid,
    input  logic [DATA_BITS-1:0]        wr_data,
    output logic                        wr_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state, state_n;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count, count_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic [DIV_W-1:0]       div_q, div_n;
    logic [DIV_W-1:0]       baud_cnt, baud_cnt_n;
    logic [BW-1:0]          bit_cnt, bit_cnt_n;
    logic                   stop2_q, stop2_n;
    logic                   tx_q, tx_n;
    logic                   busy_q, busy_n;
    logic                   ready_q, ready_n;
    logic                   push, pop, start_frame, bit_end, fifo_nonempty;
`ifdef UART_TX_PARITY_EN
    logic                   par_en_q, par_en_n;
    logic                   par_bit_q, par_bit_n;
`endif

    assign push          = wr_valid && ready_q;
    assign pop           = start_frame;
    assign fifo_nonempty = (count != '0);
    assign bit_end       = (baud_cnt == div_q - DIV_W'(1));
    assign count_n       = count + CW'(push) - CW'(pop);
    assign ready_n       = (count_n != CW'(FIFO_DEPTH));

    assign wr_ready   = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count;

    // Storage needs no reset: the cleared pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            shreg    <= '0;
            div_q    <= DIV_W'(2);
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            count    <= count_n;
            shreg    <= shreg_n;
            div_q    <= div_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            stop2_q  <= stop2_n;
            tx_q     <= tx_n;
            busy_q   <= busy_n;
            ready_q  <= ready_n;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_n;
            par_bit_q <= par_bit_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        div_n       = div_q;
        baud_cnt_n  = bit_end ? '0 : baud_cnt + DIV_W'(1);
        bit_cnt_n   = bit_cnt;
        stop2_n     = stop2_q;
        tx_n        = tx_q;
        busy_n      = busy_q;
        start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_n    = par_en_q;
        par_bit_n   = par_bit_q;
`endif

        case (state)
            IDLE: begin
                baud_cnt_n  = '0;
                start_frame = fifo_nonempty;
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    tx_n      = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_n = PARITY;
                            tx_n    = par_bit_q;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg[1];
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                    tx_n      = 1'b1;
                end
            end
`endif
            STOP: begin
                // bit_cnt counts stop bits here; a queued word starts with no idle gap.
                if (bit_end) begin
                    if (stop2_q && bit_cnt == '0) begin
                        bit_cnt_n = BW'(1);
                    end else if (fifo_nonempty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Frame start: pop the head word and freeze the line configuration for this frame.
        if (start_frame) begin
            state_n    = START;
            shreg_n    = mem[rd_ptr];
            div_n      = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
            stop2_n    = stop2;
            tx_n       = 1'b0;
            busy_n     = 1'b1;
            bit_cnt_n  = '0;
            baud_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
            par_en_n   = parity_en;
            par_bit_n  = (^mem[rd_ptr]) ^ parity_odd;
`endif
        end
    end

endmodule
